mem_arbiter: RTL
================

# mem_arbiter

Shares the single external-memory transfer engine between `NUM_REQ` cache-side requesters, such as ICache miss, DCache miss and DCache writeback. Each requester owns a one-entry request slot. The arbiter picks one valid slot by round-robin, issues a one-cycle start pulse to the memory controller, tracks the controller's `busy` level through the whole transfer, then returns a one-cycle `done` to the owner. It sits between the cache miss handlers and the memory controller's `IN_ce/IN_we/IN_cacheID/IN_sramAddr/IN_extAddr/OUT_busy` port.

## Interface
- `NUM_REQ`, default 3: number of requesters, minimum 2.
- `NUM_CACHES`, default 2: number of cache SRAMs the controller can target; sets the `cacheID` width `$clog2(NUM_CACHES)`.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-low.
- `IN_valid`  in  NUM_REQ  request present, one bit per requester.
- `OUT_ready`  out  NUM_REQ  slot i empty; request accepted when `IN_valid[i] & OUT_ready[i]`.
- `IN_we`  in  1 [NUM_REQ]  1 = cache→external write, 0 = external→cache read.
- `IN_cacheID`  in  $clog2(NUM_CACHES) [NUM_REQ]  target cache.
- `IN_sramAddr`  in  10 [NUM_REQ]  cache SRAM start address.
- `IN_extAddr`  in  30 [NUM_REQ]  external word address.
- `OUT_done`  out  NUM_REQ  one-cycle pulse when requester i's transfer completes.
- `OUT_owner`  out  $clog2(NUM_REQ)  requester currently being served.
- `OUT_ownerValid`  out  1  a transfer is issued or in flight.
- `OUT_MC_ce`  out  1  start pulse to the controller.
- `OUT_MC_we`, `OUT_MC_cacheID`, `OUT_MC_sramAddr`, `OUT_MC_extAddr`  out  1 / $clog2(NUM_CACHES) / 10 / 30  transfer descriptor; valid while `OUT_MC_ce`.
- `IN_MC_busy`  in  1  controller busy level.

## Operation
- **Slots:** slot i is loaded from the requester inputs on accept. `OUT_ready[i] = !slotValid[i]`; this is combinational from a register only. A slot clears on the edge that raises `OUT_done[i]`.
- **State machine**, states IDLE, ISSUE, WAIT_START, WAIT_END:
  - IDLE: if any slot is valid and `IN_MC_busy==0`, select a winner, register the descriptor and `OUT_MC_ce<=1`, then go to ISSUE. Otherwise stay.
  - ISSUE: `OUT_MC_ce<=0`, go to WAIT_START.
  - WAIT_START: stay until `IN_MC_busy==1`, then go to WAIT_END.
  - WAIT_END: stay until `IN_MC_busy==0`. Then `OUT_done[owner]<=1`, clear the owner slot, go to IDLE.
- **Round-robin:** a pointer `last` holds the most recent grant. The search starts at `last+1` modulo `NUM_REQ`. `last` is updated on the IDLE→ISSUE edge only.
- **Owner outputs:** `OUT_owner` is updated on issue. `OUT_ownerValid` is 1 in ISSUE, WAIT_START and WAIT_END.
- **Descriptor hold:** `OUT_MC_*` descriptor fields hold their value until the next issue.
- **Slot pinning:** a slot's contents never change while it is valid; requesters cannot cancel.

## Timing
- **Reset values (rst==0 at a clock edge):**
  - state = IDLE, all slots empty, so `OUT_ready` is all-ones.
  - `OUT_done=0`, `OUT_MC_ce=0`, `OUT_MC_we=0`, `OUT_MC_cacheID=0`, `OUT_MC_sramAddr=0`, `OUT_MC_extAddr=0`.
  - `OUT_owner=0`, `OUT_ownerValid=0`, `last=NUM_REQ-1`, so requester 0 wins first.
- **Reset mid-transfer:** the arbiter abandons the transfer with no `done`. The controller shares the system reset.
- **Start latency:** accept at edge E0 → `OUT_MC_ce` high after E1 → low after E2. The controller raises `busy` at E2, so the minimum request-to-start latency is 1 cycle after accept.
- **Completion:** `OUT_done` rises on the first edge after `IN_MC_busy` is sampled 0 in WAIT_END. It lasts exactly 1 cycle.
- **Slot reuse:** a freed slot shows `OUT_ready=1` in the same cycle as `done`. A new request is accepted at the next edge.
- **Back-to-back:** the next issue needs `busy==0` in IDLE, so the gap is one IDLE cycle after `done`.
- **Controller busy at IDLE:** no issue until `busy` is low, e.g. after an external reset skew.
- **Simultaneous events:**
  - New accept on slot j and completion on slot i in the same cycle are independent.
  - A slot accepted on edge E is eligible for arbitration from the cycle after E.
- **Missing busy:** if `busy` never rises, the arbiter waits in WAIT_START indefinitely.

## Configuration
- `MEM_ARB_RD_PRIO_EN`:
  - Defined: any valid read slot (`we==0`) beats all write slots. Round-robin applies within the winning class, using the shared `last` pointer. This reduces miss latency at the cost of writeback latency.
  - Undefined: plain round-robin with no regard to `we`.

## Test plan
- **Single read:** after reset, requester 1 sends we=0, cacheID=1, sram=0x040, ext=0x0001000. Required: `OUT_MC_ce` high for exactly 1 cycle with these fields, `OUT_owner=1`. With the model holding `busy` for 130 cycles, `OUT_done[1]` pulses once, 1 cycle after `busy` falls.
- **Round-robin:** all 3 slots valid at once. Required grant order 0, 1, 2, 0 over repeated refills. Each requester gets exactly one `done` per accept.
- **Ready/backpressure:** with slot 2 in flight, `OUT_ready[2]=0` and `IN_valid[2]` held is ignored. After `done[2]`, `OUT_ready[2]=1` and the request is accepted next edge, with no duplicate issue.
- **Busy at idle:** hold `IN_MC_busy=1` for 5 cycles with slot 0 valid. Required: no `OUT_MC_ce` until `busy` is low. Then issue on the next edge.
- **Mid-transfer reset:** assert rst=0 during WAIT_END. Required: all outputs at reset values on the next edge, and no `OUT_done`.
- **Priority macro:** with `MEM_ARB_RD_PRIO_EN`, slot 0 write and slot 1 read valid together → slot 1 granted first. Without the macro → slot 0 granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external-memory transfer engine between NUM_REQ
// cache-side requesters. Each requester owns a one-entry slot; a valid slot
// is picked round-robin, started with a one-cycle pulse to the controller,
// followed through the controller's busy level, then acknowledged with a
// one-cycle done pulse to its owner.
// Optional build macro MEM_ARB_RD_PRIO_EN: when defined, any valid read slot
// beats every write slot, with round-robin applied inside the winning class.
module mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int NUM_CACHES = 2,
    localparam int CW = $clog2(NUM_CACHES),
    localparam int OW = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  IN_valid,
    output logic [NUM_REQ-1:0]  OUT_ready,
    input  logic                IN_we       [NUM_REQ],
    input  logic [CW-1:0]       IN_cacheID  [NUM_REQ],
    input  logic [9:0]          IN_sramAddr [NUM_REQ],
    input  logic [29:0]         IN_extAddr  [NUM_REQ],
    output logic [NUM_REQ-1:0]  OUT_done,
    output logic [OW-1:0]       OUT_owner,
    output logic                OUT_ownerValid,
    output logic                OUT_MC_ce,
    output logic                OUT_MC_we,
    output logic [CW-1:0]       OUT_MC_cacheID,
    output logic [9:0]          OUT_MC_sramAddr,
    output logic [29:0]         OUT_MC_extAddr,
    input  logic                IN_MC_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_END
    } state_t;

    state_t              state_q, state_d;

    logic [NUM_REQ-1:0]  slotValid_q, slotValid_d;
    logic [NUM_REQ-1:0]  slotWe_q;
    logic [CW-1:0]       slotCache_q [NUM_REQ];
    logic [9:0]          slotSram_q  [NUM_REQ];
    logic [29:0]         slotExt_q   [NUM_REQ];

    logic [OW-1:0]       last_q, last_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                ce_q, ce_d;
    logic                mcWe_q, mcWe_d;
    logic [CW-1:0]       mcCache_q, mcCache_d;
    logic [9:0]          mcSram_q, mcSram_d;
    logic [29:0]         mcExt_q, mcExt_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                winnerFound;
    logic [OW-1:0]       winner;
    int                  candInt;
    logic [OW-1:0]       cand;
    logic                issue;
    logic                finish;
    logic [NUM_REQ-1:0]  clearMask;
    logic [NUM_REQ-1:0]  acceptMask;

    // Round-robin search starting one past the last grant, optionally restricted to reads
    always_comb begin
        eligible = slotValid_q;
`ifdef MEM_ARB_RD_PRIO_EN
        if (|(slotValid_q & ~slotWe_q)) begin
            eligible = slotValid_q & ~slotWe_q;
        end
`endif
        winnerFound = 1'b0;
        winner      = '0;
        candInt     = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candInt = int'(last_q) + k;
            cand    = OW'((candInt >= NUM_REQ) ? (candInt - NUM_REQ) : candInt);
            if (!winnerFound && eligible[cand]) begin
                winnerFound = 1'b1;
                winner      = cand;
            end
        end
    end

    // Next-state decode for the issue / wait-start / wait-end sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (issue)       state_d = ISSUE;
            ISSUE:                       state_d = WAIT_START;
            WAIT_START: if (IN_MC_busy)  state_d = WAIT_END;
            WAIT_END:   if (!IN_MC_busy) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Output and datapath next values: issue strobe, completion strobe, slot bookkeeping
    always_comb begin
        issue      = (state_q == IDLE) && winnerFound && !IN_MC_busy;
        finish     = (state_q == WAIT_END) && !IN_MC_busy;
        clearMask  = '0;
        if (finish) begin
            clearMask[owner_q] = 1'b1;
        end
        acceptMask  = IN_valid & ~slotValid_q;
        slotValid_d = (slotValid_q & ~clearMask) | acceptMask;
        done_d      = clearMask;
        ce_d        = issue;
        last_d      = last_q;
        owner_d     = owner_q;
        mcWe_d      = mcWe_q;
        mcCache_d   = mcCache_q;
        mcSram_d    = mcSram_q;
        mcExt_d     = mcExt_q;
        if (issue) begin
            last_d    = winner;
            owner_d   = winner;
            mcWe_d    = slotWe_q[winner];
            mcCache_d = slotCache_q[winner];
            mcSram_d  = slotSram_q[winner];
            mcExt_d   = slotExt_q[winner];
        end
    end

    // State and control registers; reset abandons any transfer without a done
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            slotValid_q <= '0;
            last_q      <= OW'(NUM_REQ - 1);
            owner_q     <= '0;
            done_q      <= '0;
            ce_q        <= 1'b0;
            mcWe_q      <= 1'b0;
            mcCache_q   <= '0;
            mcSram_q    <= '0;
            mcExt_q     <= '0;
        end else begin
            state_q     <= state_d;
            slotValid_q <= slotValid_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            done_q      <= done_d;
            ce_q        <= ce_d;
            mcWe_q      <= mcWe_d;
            mcCache_q   <= mcCache_d;
            mcSram_q    <= mcSram_d;
            mcExt_q     <= mcExt_d;
        end
    end

    // Slot payload capture on accept; contents stay pinned while the slot is valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acceptMask[i]) begin
                slotWe_q[i]    <= IN_we[i];
                slotCache_q[i] <= IN_cacheID[i];
                slotSram_q[i]  <= IN_sramAddr[i];
                slotExt_q[i]   <= IN_extAddr[i];
            end
        end
    end

    assign OUT_ready       = ~slotValid_q;
    assign OUT_done        = done_q;
    assign OUT_owner       = owner_q;
    assign OUT_ownerValid  = (state_q != IDLE);
    assign OUT_MC_ce       = ce_q;
    assign OUT_MC_we       = mcWe_q;
    assign OUT_MC_cacheID  = mcCache_q;
    assign OUT_MC_sramAddr = mcSram_q;
    assign OUT_MC_extAddr  = mcExt_q;

endmodule
